// File: rtl/addsub_operand_sequencer.sv
// addsub_operand_sequencer
//   Control stage around a 4-bit add/subtract unit. Operand A, operand B and
//   the op code ({c0, sub} on sw[1:0]) are collected from the switches, one
//   key_load press per field. The operands are then driven to the unit, its
//   result and flags are registered one cycle later, and they are held for
//   display. A wrapping counter tracks completed operations.
//
//   Optional build macro: ADDSUB_ACC_CHAIN_EN. When it is defined, key_load in
//   SHOW feeds the held result back as operand A, takes operand B from the
//   switches and jumps straight to op-code entry (accumulator chaining).
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   sw                    switch value, sampled on key_load only
//   key_load, key_clr     one-cycle strobes: advance / abort to IDLE
//   alu_a, alu_b          registered operands to the add/subtract unit
//   alu_c0, alu_sub       registered carry-in and op select (1 = subtract)
//   alu_f, alu_c4,
//   alu_zf, alu_cf        result and flags returned by the unit
//   res_f, res_c4,
//   res_zf, res_cf        latched result and flags
//   res_valid             res_* belong to the current sequence
//   state                 FSM state code for debug LEDs
//   op_cnt                completed-operation count (wraps)
module addsub_operand_sequencer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned OPCNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   sw,
    input  logic               key_load,
    input  logic               key_clr,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_c0,
    output logic               alu_sub,
    input  logic [WIDTH-1:0]   alu_f,
    input  logic               alu_c4,
    input  logic               alu_zf,
    input  logic               alu_cf,
    output logic [WIDTH-1:0]   res_f,
    output logic               res_c4,
    output logic               res_zf,
    output logic               res_cf,
    output logic               res_valid,
    output logic [2:0]         state,
    output logic [OPCNT_W-1:0] op_cnt
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StGetB  = 3'd1,
        StGetOp = 3'd2,
        StExec  = 3'd3,
        StCapt  = 3'd4,
        StShow  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, f_q, f_d;
    logic               c0_q, c0_d, sub_q, sub_d;
    logic               c4_q, c4_d, zf_q, zf_d, cf_q, cf_d;
    logic               valid_q, valid_d;
    logic [OPCNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c0_q    <= 1'b0;
            sub_q   <= 1'b0;
            f_q     <= '0;
            c4_q    <= 1'b0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c0_q    <= c0_d;
            sub_q   <= sub_d;
            f_q     <= f_d;
            c4_q    <= c4_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c0_d    = c0_q;
        sub_d   = sub_q;
        f_d     = f_q;
        c4_d    = c4_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        // Abort has priority over everything, including a coincident load.
        if (key_clr) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (key_load) begin
                        a_d     = sw;
                        state_d = StGetB;
                    end
                end
                StGetB: begin
                    if (key_load) begin
                        b_d     = sw;
                        state_d = StGetOp;
                    end
                end
                StGetOp: begin
                    if (key_load) begin
                        sub_d   = sw[0];
                        c0_d    = sw[1];
                        state_d = StExec;
                    end
                end
                // One settle cycle for the combinational unit.
                StExec: state_d = StCapt;
                StCapt: begin
                    f_d     = alu_f;
                    c4_d    = alu_c4;
                    zf_d    = alu_zf;
                    cf_d    = alu_cf;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StShow;
                end
                StShow: begin
                    if (key_load) begin
                        valid_d = 1'b0;
`ifdef ADDSUB_ACC_CHAIN_EN
                        a_d     = f_q;
                        b_d     = sw;
                        state_d = StGetOp;
`else
                        a_d     = sw;
                        state_d = StGetB;
`endif
                    end
                end
                // Unused codes 6 and 7 fall back to IDLE.
                default: state_d = StIdle;
            endcase
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_c0    = c0_q;
    assign alu_sub   = sub_q;
    assign res_f     = f_q;
    assign res_c4    = c4_q;
    assign res_zf    = zf_q;
    assign res_cf    = cf_q;
    assign res_valid = valid_q;
    assign state     = state_q;
    assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_addsub_operand_sequencer.sv
// Bench for addsub_operand_sequencer: two instances (OPCNT_W = 8 and 2) share
// the same stimulus. Each is wired to a behavioural add/subtract unit. A
// step-level reference model predicts every output and is compared on each
// falling edge; literal checks pin the model on the worked examples.
module tb_addsub_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       key_load, key_clr;

    logic [3:0] alu_a, alu_b, alu_f, res_f;
    logic       alu_c0, alu_sub, alu_c4, alu_zf, alu_cf;
    logic       res_c4, res_zf, res_cf, res_valid;
    logic [2:0] state;
    logic [7:0] op_cnt;

    logic [3:0] alu2_a, alu2_b, alu2_f, res2_f;
    logic       alu2_c0, alu2_sub, alu2_c4, alu2_zf, alu2_cf;
    logic       res2_c4, res2_zf, res2_cf, res2_valid;
    logic [2:0] state2;
    logic [1:0] op_cnt2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Add/subtract unit: add {c4,f} = a+b+c0; subtract {c4,f} = a-b-c0 with c4
    // the borrow; zf = (f == 0); cf = c4 ^ sub. Returns {cf, zf, c4, f}.
    function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic sub, input logic c0);
        logic [4:0] r;
        if (sub) r = {1'b0, a} - {1'b0, b} - {4'd0, c0};
        else     r = {1'b0, a} + {1'b0, b} + {4'd0, c0};
        return {r[4] ^ sub, (r[3:0] == 4'd0), r[4], r[3:0]};
    endfunction

    assign {alu_cf, alu_zf, alu_c4, alu_f}     = alu_ref(alu_a, alu_b, alu_sub, alu_c0);
    assign {alu2_cf, alu2_zf, alu2_c4, alu2_f} = alu_ref(alu2_a, alu2_b, alu2_sub, alu2_c0);

    addsub_operand_sequencer #(.WIDTH(4), .OPCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .key_load(key_load), .key_clr(key_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c0(alu_c0), .alu_sub(alu_sub),
        .alu_f(alu_f), .alu_c4(alu_c4), .alu_zf(alu_zf), .alu_cf(alu_cf),
        .res_f(res_f), .res_c4(res_c4), .res_zf(res_zf), .res_cf(res_cf),
        .res_valid(res_valid), .state(state), .op_cnt(op_cnt)
    );

    addsub_operand_sequencer #(.WIDTH(4), .OPCNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sw(sw), .key_load(key_load), .key_clr(key_clr),
        .alu_a(alu2_a), .alu_b(alu2_b), .alu_c0(alu2_c0), .alu_sub(alu2_sub),
        .alu_f(alu2_f), .alu_c4(alu2_c4), .alu_zf(alu2_zf), .alu_cf(alu2_cf),
        .res_f(res2_f), .res_c4(res2_c4), .res_zf(res2_zf), .res_cf(res2_cf),
        .res_valid(res2_valid), .state(state2), .op_cnt(op_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_step is the sequence step (0 collect A, 1 collect B,
    // 2 collect op, 3 settle, 4 capture, 5 show), which is also the state code.
    int         m_step;
    logic [3:0] m_a, m_b, m_f;
    logic       m_sub, m_c0, m_c4, m_zf, m_cf, m_valid;
    int         m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step <= 0; m_a <= 4'd0; m_b <= 4'd0; m_sub <= 1'b0; m_c0 <= 1'b0;
            m_f <= 4'd0; m_c4 <= 1'b0; m_zf <= 1'b0; m_cf <= 1'b0; m_valid <= 1'b0;
            m_cnt <= 0;
        end else if (key_clr) begin
            m_step  <= 0;
            m_valid <= 1'b0;
        end else if (m_step == 3) begin
            m_step <= 4;
        end else if (m_step == 4) begin
            {m_cf, m_zf, m_c4, m_f} <= alu_ref(m_a, m_b, m_sub, m_c0);
            m_valid <= 1'b1;
            m_cnt   <= m_cnt + 1;
            m_step  <= 5;
        end else if (key_load) begin
            if (m_step == 0) begin
                m_a <= sw; m_step <= 1;
            end else if (m_step == 1) begin
                m_b <= sw; m_step <= 2;
            end else if (m_step == 2) begin
                m_sub <= sw[0]; m_c0 <= sw[1]; m_step <= 3;
            end else begin
                m_valid <= 1'b0;
`ifdef ADDSUB_ACC_CHAIN_EN
                m_a <= m_f; m_b <= sw; m_step <= 2;
`else
                m_a <= sw; m_step <= 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("state",     32'(state),     32'(m_step));
        check("alu_a",     32'(alu_a),     32'(m_a));
        check("alu_b",     32'(alu_b),     32'(m_b));
        check("alu_sub",   32'(alu_sub),   32'(m_sub));
        check("alu_c0",    32'(alu_c0),    32'(m_c0));
        check("res_f",     32'(res_f),     32'(m_f));
        check("res_c4",    32'(res_c4),    32'(m_c4));
        check("res_zf",    32'(res_zf),    32'(m_zf));
        check("res_cf",    32'(res_cf),    32'(m_cf));
        check("res_valid", 32'(res_valid), 32'(m_valid));
        check("op_cnt",    32'(op_cnt),    32'(m_cnt % 256));
        check("state_w2",  32'(state2),    32'(m_step));
        check("op_cnt_w2", 32'(op_cnt2),   32'(m_cnt % 4));
    end

    // All stimulus tasks start and end 2 time units after a rising edge.
    task automatic press(input logic [3:0] v);
        sw = v; key_load = 1'b1;
        @(posedge clk); #2;
        key_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clr_pulse(input logic with_load);
        key_clr = 1'b1; key_load = with_load; sw = 4'd6;
        @(posedge clk); #2;
        key_clr = 1'b0; key_load = 1'b0;
    endtask

    task automatic check_res(input string tag, input int f, input int c4, input int zf,
                             input int cf);
        check({tag, "_f"},  32'(res_f),  f);
        check({tag, "_c4"}, 32'(res_c4), c4);
        check({tag, "_zf"}, 32'(res_zf), zf);
        check({tag, "_cf"}, 32'(res_cf), cf);
        check({tag, "_valid"}, 32'(res_valid), 1);
    endtask

    int saved_cnt;

    initial begin
        rst_n = 1'b0; sw = 4'd0; key_load = 1'b0; key_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_state", 32'(state), 0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_cnt",   32'(op_cnt), 0);
        rst_n = 1'b1;
        idle(1);

        // 5 + 3, add, c0 = 0: result two edges after the op press.
        press(4'd5); press(4'd3); press(4'd0);
        idle(2);
        check_res("add53", 8, 0, 0, 0);
        check("add53_cnt", 32'(op_cnt), 1);
`ifdef ADDSUB_ACC_CHAIN_EN
        // Chain: 8 + 4 = 12.
        press(4'd4); press(4'd0);
        idle(2);
        check_res("chain", 12, 0, 0, 0);
        check("chain_cnt", 32'(op_cnt), 2);
`else
        press(4'd9); press(4'd8); press(4'b0010);
        idle(2);
        check_res("add98c", 2, 1, 0, 1);
        check("add98c_cnt", 32'(op_cnt), 2);
        press(4'd8); press(4'd8); press(4'd0);
        idle(2);
        check_res("add88", 0, 1, 1, 1);
        press(4'd7); press(4'd7); press(4'b0001);
        idle(2);
        check_res("sub77", 0, 0, 1, 1);
        check("sub77_cnt", 32'(op_cnt), 4);
`endif

        // Abort from GET_OP, alone and together with key_load.
        clr_pulse(1'b0);
        press(4'd1); press(4'd2);
        saved_cnt = m_cnt;
        check("pre_clr_state", 32'(state), 2);
        clr_pulse(1'b0);
        check("clr_state", 32'(state), 0);
        check("clr_valid", 32'(res_valid), 0);
        check("clr_cnt",   32'(op_cnt), 32'(saved_cnt));
        press(4'd1); press(4'd2);
        clr_pulse(1'b1);
        check("clrld_state", 32'(state), 0);
        check("clrld_cnt",   32'(op_cnt), 32'(saved_cnt));

        // Asynchronous reset while in EXEC.
        press(4'd3); press(4'd4); press(4'b0011);
        check("pre_rst_state", 32'(state), 3);
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_a",     32'(alu_a), 0);
        check("arst_b",     32'(alu_b), 0);
        check("arst_sub",   32'(alu_sub), 0);
        check("arst_c0",    32'(alu_c0), 0);
        check("arst_f",     32'(res_f), 0);
        check("arst_valid", 32'(res_valid), 0);
        check("arst_cnt",   32'(op_cnt), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(1);

        // Five operations: narrow counter wraps 1, 2, 3, 0, 1.
        for (int i = 1; i <= 5; i++) begin
`ifdef ADDSUB_ACC_CHAIN_EN
            if (i == 1) press(4'(i));
`else
            press(4'(i));
`endif
            press(4'(i + 1)); press(4'd0);
            idle(2);
            check("seq_cnt", 32'(op_cnt), i);
            check("seq_cnt_w2", 32'(op_cnt2), i % 4);
        end

        // Randomized run against the model.
        repeat (3000) begin
            sw       = 4'($urandom);
            key_load = (($urandom % 100) < 40);
            key_clr  = (($urandom % 100) < 4);
            @(posedge clk); #2;
        end
        key_load = 1'b0; key_clr = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
